// File: rtl/freq_pkg.sv
// Shared constants and types for the frequency BCD display path.
// Holds converter widths, saturation limit, unit codes and FSM states.
package freq_pkg;

  localparam int BIN_W = 30;
  localparam int DIG_N = 9;
  localparam int BCD_W = 4 * DIG_N;
  localparam int CNT_W = 5;

  localparam logic [BIN_W-1:0] MAX_VAL = 30'd999_999_999;

  localparam logic [1:0] UNIT_HZ  = 2'd0;
  localparam logic [1:0] UNIT_KHZ = 2'd1;
  localparam logic [1:0] UNIT_MHZ = 2'd2;

  localparam logic [5:0] DP_3 = 6'b001000;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SHIFT,
    ST_DONE
  } state_e;

endpackage

// File: rtl/bcd_add3.sv
// Double-dabble nibble adjust: values of 5 or more get +3 before a shift.
// Ports: in_i (BCD nibble), out_o (adjusted nibble).
module bcd_add3 (
  input  logic [3:0] in_i,
  output logic [3:0] out_o
);

  assign out_o = (in_i >= 4'd5) ? in_i + 4'd3 : in_i;

endmodule

// File: rtl/freq_bcd_disp.sv
// Converts each new frequency reading to 9 BCD digits and auto-ranges it.
// Ports: sys_clk/sys_rst_n, freq_data in; bcd/disp/unit/point/ovf/done out.
module freq_bcd_disp
  import freq_pkg::*;
#(
  parameter int IN_W = 50
) (
  input  logic            sys_clk,
  input  logic            sys_rst_n,
  input  logic [IN_W-1:0] freq_data,
  output logic [35:0]     bcd_data,
  output logic [23:0]     disp_data,
  output logic [1:0]      unit,
  output logic [5:0]      point,
  output logic            ovf,
  output logic            conv_done
);

  state_e            state_q;
  logic [IN_W-1:0]   last_q;
  logic [BIN_W-1:0]  bin_q;
  logic [BCD_W-1:0]  bcd_sh_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              ovf_nxt_q;

  logic [BCD_W-1:0]  adj_d;
  logic              ovf_d;
  logic [BIN_W-1:0]  sat_d;
  logic [23:0]       disp_d;
  logic [1:0]        unit_d;
  logic [5:0]        point_d;

  for (genvar g = 0; g < DIG_N; g++) begin : g_add3
    bcd_add3 u_add3 (
      .in_i  (bcd_sh_q[4*g +: 4]),
      .out_o (adj_d[4*g +: 4])
    );
  end

  // Full-width compare so high input bits can never alias below the ceiling.
  assign ovf_d = freq_data > IN_W'(MAX_VAL);
  assign sat_d = ovf_d ? MAX_VAL : freq_data[BIN_W-1:0];

  // Autorange from the finished digits; the MHz test must win over kHz.
  always_comb begin
    unit_d  = UNIT_HZ;
    disp_d  = bcd_sh_q[23:0];
    point_d = '0;
    priority case (1'b1)
      (|bcd_sh_q[35:24]): begin
        unit_d  = UNIT_MHZ;
        disp_d  = bcd_sh_q[35:12];
        point_d = DP_3;
      end
      (|bcd_sh_q[23:12]): begin
        unit_d  = UNIT_KHZ;
        point_d = DP_3;
      end
      default: ;
    endcase
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q   <= ST_IDLE;
      last_q    <= '0;
      bin_q     <= '0;
      bcd_sh_q  <= '0;
      cnt_q     <= '0;
      ovf_nxt_q <= 1'b0;
      bcd_data  <= '0;
      disp_data <= '0;
      unit      <= '0;
      point     <= '0;
      ovf       <= 1'b0;
      conv_done <= 1'b0;
    end else begin
      conv_done <= 1'b0;
      unique case (state_q)
        ST_IDLE: begin
          if (freq_data != last_q) begin
            last_q    <= freq_data;
            bin_q     <= sat_d;
            ovf_nxt_q <= ovf_d;
            bcd_sh_q  <= '0;
            cnt_q     <= '0;
            state_q   <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          bcd_sh_q <= {adj_d[BCD_W-2:0], bin_q[BIN_W-1]};
          bin_q    <= {bin_q[BIN_W-2:0], 1'b0};
          cnt_q    <= cnt_q + 1'b1;
          if (cnt_q == CNT_W'(BIN_W - 1)) begin
            state_q <= ST_DONE;
          end
        end
        ST_DONE: begin
          bcd_data  <= bcd_sh_q;
          disp_data <= disp_d;
          unit      <= unit_d;
          point     <= point_d;
          ovf       <= ovf_nxt_q;
          conv_done <= 1'b1;
          state_q   <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_freq_bcd_disp.sv
// Randomised and directed bench for freq_bcd_disp against a decimal model.
// The model converts values with plain arithmetic and times results by cycle.
module tb_freq_bcd_disp;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [49:0] freq = '0;
  logic [35:0] bcd_data;
  logic [23:0] disp_data;
  logic [1:0]  unit;
  logic [5:0]  point;
  logic        ovf;
  logic        conv_done;

  int vectors = 0;
  int miscompares = 0;
  int fail_prints = 0;
  bit chk_en = 1'b0;

  freq_bcd_disp #(.IN_W(50)) dut (
    .sys_clk   (clk),
    .sys_rst_n (rst_n),
    .freq_data (freq),
    .bcd_data  (bcd_data),
    .disp_data (disp_data),
    .unit      (unit),
    .point     (point),
    .ovf       (ovf),
    .conv_done (conv_done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      if (fail_prints < 40) begin
        fail_prints++;
        $display("FAIL %s at %0t: got %0h expected %0h",
                 name, $time, act, exp);
      end
    end
  endtask

  function automatic logic [35:0] to_bcd(input longint unsigned v);
    logic [35:0] r;
    longint unsigned x;
    r = '0;
    x = v;
    for (int i = 0; i < 9; i++) begin
      r[4*i +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  // Expected outputs for a value, straight from the decimal rules.
  task automatic calc(input longint unsigned v, output logic [35:0] e_bcd,
                      output logic [23:0] e_disp, output logic [1:0] e_unit,
                      output logic [5:0] e_point, output logic e_ovf);
    longint unsigned sat;
    logic [35:0] tmp;
    e_ovf = v > 64'd999_999_999;
    sat   = e_ovf ? 64'd999_999_999 : v;
    e_bcd = to_bcd(sat);
    if (sat >= 1_000_000) begin
      tmp = to_bcd(sat / 1000);
      e_unit = 2'd2;
      e_point = 6'b001000;
    end else if (sat >= 1000) begin
      tmp = to_bcd(sat);
      e_unit = 2'd1;
      e_point = 6'b001000;
    end else begin
      tmp = to_bcd(sat);
      e_unit = 2'd0;
      e_point = 6'b000000;
    end
    e_disp = tmp[23:0];
  endtask

  logic [49:0] m_last = '0;
  logic [49:0] m_pend = '0;
  int          m_busy = 0;
  logic [35:0] e_bcd = '0;
  logic [23:0] e_disp = '0;
  logic [1:0]  e_unit = '0;
  logic [5:0]  e_point = '0;
  logic        e_ovf = 1'b0;
  logic        e_done = 1'b0;

  // A new value is taken when idle; its results appear 31 edges later.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_last = '0; m_pend = '0; m_busy = 0;
      e_bcd = '0; e_disp = '0; e_unit = '0;
      e_point = '0; e_ovf = 1'b0; e_done = 1'b0;
    end else begin
      e_done = 1'b0;
      if (m_busy == 0) begin
        if (freq != m_last) begin
          m_last = freq;
          m_pend = freq;
          m_busy = 31;
        end
      end else begin
        m_busy--;
        if (m_busy == 0) begin
          calc(64'(m_pend), e_bcd, e_disp, e_unit, e_point, e_ovf);
          e_done = 1'b1;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("bcd_data", 64'(bcd_data), 64'(e_bcd));
      chk("disp_data", 64'(disp_data), 64'(e_disp));
      chk("unit", 64'(unit), 64'(e_unit));
      chk("point", 64'(point), 64'(e_point));
      chk("ovf", 64'(ovf), 64'(e_ovf));
      chk("conv_done", 64'(conv_done), 64'(e_done));
    end
  end

  task automatic wait_done(output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!conv_done && n < 200);
    if (!conv_done) chk("done_timeout", 64'(n), 64'd0);
  endtask

  task automatic conv(input logic [49:0] v, output int n);
    @(negedge clk);
    freq = v;
    wait_done(n);
  endtask

  task automatic count_pulses(input int cycles, output int p);
    p = 0;
    repeat (cycles) begin
      @(negedge clk);
      if (conv_done) p++;
    end
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    int p;
    int sel;
    logic [49:0] v;

    #1 rst_n = 1'b0;
    #1 chk_en = 1'b1;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // Zero after reset matches last_val, so nothing should happen.
    count_pulses(20, p);
    chk("idle_zero_pulses", 64'(p), 64'd0);
    chk("reset_bcd", 64'(bcd_data), 64'd0);

    conv(50'd123_456_789, n);
    chk("latency", 64'(n), 64'd32);
    chk("lit_bcd_123456789", 64'(bcd_data), 64'h1_2345_6789);
    chk("lit_disp_123456", 64'(disp_data), 64'h12_3456);
    chk("lit_unit_mhz", 64'(unit), 64'd2);
    chk("lit_point_mhz", 64'(point), 64'b001000);
    chk("lit_ovf_0", 64'(ovf), 64'd0);

    conv(50'd999, n);
    chk("lit_bcd_999", 64'(bcd_data), 64'h0_0000_0999);
    chk("lit_disp_999", 64'(disp_data), 64'h00_0999);
    chk("lit_unit_hz", 64'(unit), 64'd0);
    chk("lit_point_hz", 64'(point), 64'd0);

    conv(50'd1000, n);
    chk("lit_disp_1000", 64'(disp_data), 64'h00_1000);
    chk("lit_unit_khz", 64'(unit), 64'd1);
    chk("lit_point_khz", 64'(point), 64'b001000);

    conv(50'd1_099_511_627_776, n);
    chk("lit_ovf_1", 64'(ovf), 64'd1);
    chk("lit_bcd_sat", 64'(bcd_data), 64'h9_9999_9999);
    chk("lit_disp_sat", 64'(disp_data), 64'h99_9999);
    chk("lit_unit_sat", 64'(unit), 64'd2);

    conv(50'd7, n);
    @(negedge clk);
    freq = 50'd100_000;
    repeat (10) @(negedge clk);
    freq = 50'd250_000;
    wait_done(n);
    chk("mid_first_disp", 64'(disp_data), 64'h10_0000);
    chk("mid_first_unit", 64'(unit), 64'd1);
    wait_done(n);
    chk("mid_second_gap", 64'(n), 64'd32);
    chk("mid_second_disp", 64'(disp_data), 64'h25_0000);
    count_pulses(60, p);
    chk("mid_extra_pulses", 64'(p), 64'd0);

    count_pulses(500, p);
    chk("hold_pulses", 64'(p), 64'd0);
    chk("hold_disp", 64'(disp_data), 64'h25_0000);

    @(negedge clk);
    freq = 50'd75_000;
    repeat (10) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_bcd", 64'(bcd_data), 64'd0);
    chk("rst_disp", 64'(disp_data), 64'd0);
    chk("rst_unit", 64'(unit), 64'd0);
    chk("rst_done", 64'(conv_done), 64'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    wait_done(n);
    chk("rst_latency", 64'(n), 64'd32);
    chk("rst_disp_75000", 64'(disp_data), 64'h07_5000);
    chk("rst_unit_75000", 64'(unit), 64'd1);

    for (int i = 0; i < 80; i++) begin
      @(negedge clk);
      sel = $urandom_range(0, 4);
      case (sel)
        0: v = 50'($urandom_range(0, 999));
        1: v = 50'($urandom_range(1000, 999_999));
        2: v = 50'($urandom_range(1_000_000, 999_999_999));
        3: v = 50'({$urandom(), $urandom()});
        default: v = freq;
      endcase
      freq = v;
      repeat ($urandom_range(0, 45)) @(negedge clk);
    end

    repeat (80) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/freq_bcd_disp.md
Name: freq_bcd_disp

Overview:
- Downstream consumer of the frequency meter's 50-bit freq_data (Hz, registered in sys_clk domain).
- Detects each new measurement and converts it to 9 BCD digits with a sequential shift-add-3 (double-dabble) engine.
- Auto-ranges the result into a 6-digit display word with unit code and decimal-point mask for the seven-segment driver.

Parameters:
IN_W, 50, width of freq_data input
BIN_W, 30, converted binary width (fixed; covers 999_999_999)
MAX_VAL, 30'd999_999_999, saturation ceiling

Ports:
sys_clk  in  1  system clock, 50 MHz
sys_rst_n  in  1  asynchronous active-low reset
freq_data  in  IN_W  measured frequency in Hz, sys_clk domain
bcd_data  out  36  9 BCD digits, d8 in [35:32] .. d0 (ones) in [3:0]
disp_data  out  24  6 BCD digits for display, leftmost in [23:20]
unit  out  2  0 = Hz, 1 = kHz, 2 = MHz, 3 unused
point  out  6  one-hot decimal-point mask, bit i = after display digit i (digit 0 rightmost)
ovf  out  1  input exceeded MAX_VAL, value saturated
conv_done  out  1  one-cycle pulse when all outputs update

Behaviour:
- Reset (async, sys_rst_n low): all outputs 0, last_val = 0, state IDLE, shift/count regs 0.
- Fixed reset and polarity: one clock sys_clk; reset is asynchronous, active-low (sys_rst_n).
- States: IDLE, SHIFT, DONE.
- IDLE, capture edge:
  - Fires when freq_data != last_val.
  - last_val <= freq_data.
  - bin <= (freq_data > MAX_VAL) ? MAX_VAL : freq_data[BIN_W-1:0].
  - ovf_nxt <= (freq_data > MAX_VAL); full IN_W compare.
  - bcd_sh <= 0; cnt <= 0; go SHIFT.
- SHIFT, each edge:
  - Every BCD nibble >= 5 gets +3 (combinational).
  - Then {bcd_sh, bin} shifts left by 1; cnt++.
  - When cnt == BIN_W-1, go DONE (exactly BIN_W shift edges).
- DONE, one edge:
  - Register bcd_data, disp_data, unit, point, ovf.
  - conv_done = 1 for that one cycle; go IDLE.
- Latency: capture edge E0 -> shifts E1..E30 -> outputs and conv_done valid after E31.
- Outputs hold between conversions.
- Autorange (from final digits d8..d0, computed in DONE):
  - d8|d7|d6 nonzero: unit = 2, disp = d8..d3, point = 6'b001000.
  - Else d5|d4|d3 nonzero: unit = 1, disp = d5..d0, point = 6'b001000.
  - Else: unit = 0, disp = d5..d0, point = 0.
  - No leading-zero blanking; that belongs to the display driver.
- freq_data changes during SHIFT/DONE:
  - Ignored; the conversion in flight completes.
  - On return to IDLE the mismatch against last_val triggers a new capture on the next edge.
  - Intermediate values are not queued; only the latest value is converted.
- freq_data == last_val: stays IDLE, no conv_done.
  - After reset, freq_data = 0 produces no conversion; zero outputs are already correct.
- Reset asserted mid-conversion: immediate return to reset values.
  - First edge after release recaptures if freq_data != 0.

Decomposition:
- Shared package freq_pkg holds:
  - UNIT_HZ / UNIT_KHZ / UNIT_MHZ codes
  - BIN_W = 30, DIG_N = 9, MAX_VAL
  - DP_3 = 6'b001000
- One sub-module: bcd_add3, a combinational nibble adjust (in >= 5 ? in+3 : in), instantiated DIG_N times.
- FSM, counter, saturation and autorange live in freq_bcd_disp.

Test Plan:
- freq_data 0 -> 123_456_789 -> conv_done exactly 31 cycles after capture edge; bcd_data 36'h123456789, disp_data 24'h123456, unit 2, point 6'b001000, ovf 0.
- freq_data 999 -> bcd_data 36'h000000999, disp_data 24'h000999, unit 0, point 0. Then freq_data 1000 -> disp_data 24'h001000, unit 1, point 6'b001000.
- freq_data 50'd1_099_511_627_776 (2^40) -> ovf 1, bcd_data 36'h999999999, unit 2, disp_data 24'h999999.
- freq_data changed 10 cycles into a conversion (100_000 -> 250_000, original conversion from 7) -> first conv_done shows 100_000 (unit 1, disp 24'h100000). Second capture occurs 1 cycle after DONE; second conv_done shows 250_000. Exactly two pulses.
- freq_data held constant 500 cycles after a conversion -> no further conv_done, outputs stable.
- sys_rst_n pulsed low mid-SHIFT with freq_data = 75_000 -> outputs 0 immediately. After release, fresh conversion completes with disp_data 24'h075000, unit 1.
